// File: rtl/conv_1st_pkg.sv
// Shared definitions for the first-layer convolution result path.
package conv_1st_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned WN_W   = 5;

    // ReLU, arithmetic right shift by sh (truncating), saturate to 0..255.
    function automatic logic [7:0] relu_quant(input logic signed [31:0] x,
                                              input int unsigned        sh);
        logic signed [31:0] v;
        v = x >>> sh;
        if (x < 0) begin
            return 8'd0;
        end
        if (v > 32'sd255) begin
            return 8'hFF;
        end
        return v[7:0];
    endfunction

endpackage

// File: rtl/conv_1st_fifo.sv
// Synchronous show-ahead FIFO with registered occupancy count.
module conv_1st_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 40
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr_en, rd_en;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign rd_en = pop && !empty;
    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    assign wr_en = push && (!full || rd_en);
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];

    // Next-state for storage, pointers and count.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/conv_1st_collect.sv
// Collects systolic-array lane sums, requantizes, packs, tags and queues them.
module conv_1st_collect import conv_1st_pkg::*; #(
    parameter int unsigned LANES = 4,
    parameter int unsigned DW    = 16,
    parameter int unsigned SHIFT = 6,
    parameter int unsigned MAPS  = 32,
    parameter int unsigned BEATS = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_i,
    input  logic [WN_W-1:0]     weight_num,
    input  logic [LANES*DW-1:0] psum_i,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [LANES*8-1:0]  m_data,
    output logic [ADDR_W-1:0]   m_addr,
    output logic                busy,
    output logic                done,
    output logic                overflow
);

    localparam int unsigned BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned FW = LANES * 8 + ADDR_W;

    state_e               state_q, state_d;
    logic [BW-1:0]        beat_q, beat_d;
    logic [WN_W-1:0]      last_wn_q, last_wn_d;
    logic                 have_last_q, have_last_d;
    logic                 s1_valid_q, s1_valid_d;
    logic [LANES*8-1:0]   s1_data_q, s1_data_d;
    logic [ADDR_W-1:0]    s1_addr_q, s1_addr_d;
    logic                 overflow_q, overflow_d;

    logic [BW-1:0]        beat_cur;
    logic [LANES*8-1:0]   packed_w;
    logic                 last_beat;
    logic                 frame_end;
    logic                 fifo_full, fifo_empty;
    logic [FW-1:0]        fifo_rdata;

    // Per-lane ReLU + requantization into the packed output word.
    always_comb begin
        packed_w = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            packed_w[k*8 +: 8] = relu_quant(32'($signed(psum_i[k*DW +: DW])), SHIFT);
        end
    end

    // Beat index for the current strobe: restarts on a new map, else wraps.
    always_comb begin
        beat_cur = '0;
        if (have_last_q && (weight_num == last_wn_q)) begin
            beat_cur = (beat_q == BW'(BEATS - 1)) ? '0 : beat_q + 1'b1;
        end
        last_beat = (weight_num == WN_W'(MAPS - 1)) && (beat_cur == BW'(BEATS - 1));
        // A strobe arriving in the final cycle would refill stage 1, so it holds off completion.
        frame_end = (state_q == ST_DRAIN) && fifo_empty && !s1_valid_q && !valid_i;
    end

    // Stage-1 capture, beat tracking and sticky overflow.
    always_comb begin
        beat_d      = beat_q;
        last_wn_d   = last_wn_q;
        have_last_d = have_last_q;
        s1_valid_d  = valid_i;
        s1_data_d   = s1_data_q;
        s1_addr_d   = s1_addr_q;
        overflow_d  = overflow_q | (s1_valid_q && fifo_full && !m_ready);
        if (valid_i) begin
            beat_d      = beat_cur;
            last_wn_d   = weight_num;
            have_last_d = 1'b1;
            s1_data_d   = packed_w;
            s1_addr_d   = ADDR_W'(weight_num) * ADDR_W'(BEATS) + ADDR_W'(beat_cur);
        end
        if (frame_end) begin
            have_last_d = 1'b0;
        end
    end

    // Frame FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (valid_i) state_d = last_beat ? ST_DRAIN : ST_RUN;
            ST_RUN:   if (valid_i && last_beat) state_d = ST_DRAIN;
            ST_DRAIN: if (frame_end) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            last_wn_q   <= '0;
            have_last_q <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_addr_q   <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            last_wn_q   <= last_wn_d;
            have_last_q <= have_last_d;
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_addr_q   <= s1_addr_d;
            overflow_q  <= overflow_d;
        end
    end

    conv_1st_fifo #(
        .DEPTH (DEPTH),
        .W     (FW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s1_valid_q),
        .pop   (m_ready),
        .wdata ({s1_addr_q, s1_data_q}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign m_valid  = !fifo_empty;
    assign m_data   = fifo_rdata[LANES*8-1:0];
    assign m_addr   = fifo_rdata[FW-1 -: ADDR_W];
    assign busy     = (state_q != ST_IDLE);
    assign done     = frame_end;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_conv_1st_collect.sv
// Self-checking bench for conv_1st_collect: queue-level model plus directed checks.
module tb_conv_1st_collect;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [4:0]  weight_num;
    logic [63:0] psum_i;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [7:0]  m_addr;
    logic        busy;
    logic        done;
    logic        overflow;

    int nchecks = 0;
    int nfail   = 0;

    always #5 clk = ~clk;

    conv_1st_collect #(
        .LANES (4),
        .DW    (16),
        .SHIFT (6),
        .MAPS  (32),
        .BEATS (2),
        .DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .weight_num (weight_num),
        .psum_i     (psum_i),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_addr     (m_addr),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [31:0] d;
        logic [7:0]  a;
    } word_t;

    word_t mq[$];
    word_t s1_w;
    bit    s1_v;
    bit    ovf_e;
    int    phase;      // 0 idle, 1 running, 2 last beat seen
    bit    have_last;
    int    last_wn;
    int    beat_n;
    int    b;
    bit    fin;

    function automatic int q8(input int x);
        int v;
        if (x < 0) return 0;
        v = x / 64;
        return (v > 255) ? 255 : v;
    endfunction

    function automatic logic [31:0] pack(input logic [63:0] p);
        logic [31:0] r;
        logic [15:0] s;
        for (int k = 0; k < 4; k++) begin
            s = p[k*16 +: 16];
            r[k*8 +: 8] = 8'(q8(int'($signed(s))));
        end
        return r;
    endfunction

    function automatic logic [63:0] mk(input int l0, input int l1, input int l2, input int l3);
        return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            s1_v      = 0;
            ovf_e     = 0;
            phase     = 0;
            have_last = 0;
            last_wn   = 0;
            beat_n    = 0;
        end else begin
            fin = (phase == 2) && (mq.size() == 0) && !s1_v && !valid_i;
            if (m_ready && mq.size() > 0) void'(mq.pop_front());
            if (s1_v) begin
                if (mq.size() < 4) mq.push_back(s1_w);
                else ovf_e = 1;
            end
            if (valid_i) begin
                b = (have_last && int'(weight_num) == last_wn) ? (beat_n + 1) % 2 : 0;
                s1_w.a    = 8'(int'(weight_num) * 2 + b);
                s1_w.d    = pack(psum_i);
                last_wn   = int'(weight_num);
                beat_n    = b;
                have_last = 1;
                s1_v      = 1;
                if (phase == 0) phase = 1;
                if (weight_num == 5'd31 && b == 1) phase = 2;
            end else begin
                s1_v = 0;
            end
            if (fin) begin
                phase     = 0;
                have_last = 0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("m_valid", m_valid, mq.size() > 0);
            if (mq.size() > 0) begin
                chk("m_data", m_data, mq[0].d);
                chk("m_addr", m_addr, mq[0].a);
            end
            chk("busy", busy, phase != 0);
            chk("done", done, (phase == 2) && (mq.size() == 0) && !s1_v && !valid_i);
            chk("overflow", overflow, ovf_e);
        end
    end

    // Observed handshakes and done pulses.
    logic [7:0] obs[$];
    int         done_cnt = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid && m_ready) obs.push_back(m_addr);
            if (done) done_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [4:0] wn, input logic [63:0] ps);
        valid_i    = 1'b1;
        weight_num = wn;
        psum_i     = ps;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(1);
        obs.delete();
    endtask

    task automatic chk_obs(input string nm, input int exp_a[$]);
        chk({nm, "_count"}, obs.size(), exp_a.size());
        for (int i = 0; i < exp_a.size() && i < obs.size(); i++) begin
            chk(nm, obs[i], exp_a[i]);
        end
    endtask

    logic [31:0] held;
    int          base;

    initial begin
        rst = 1'b1; valid_i = 1'b0; weight_num = '0; psum_i = '0; m_ready = 1'b1;
        idle(2);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        rst = 1'b0;
        idle(1);

        // Single beat: latency 2, literal lane results.
        beat(5'd0, mk(-5, 64, 1000, 20000));
        chk("sb_latency", m_valid, 0);
        idle(1);
        #1;
        chk("sb_valid", m_valid, 1);
        chk("sb_data", m_data, 32'hFF0F_0100);
        chk("sb_addr", m_addr, 0);
        chk("sb_busy", busy, 1);

        // Full frame, controller spacing.
        do_reset();
        base = done_cnt;
        for (int i = 0; i < 64; i++) begin
            beat(5'(i / 2), mk(i * 100 - 200, i * 500, 30000 - i * 7, -i));
            idle(8);
        end
        for (int c = 0; c < 60 && done_cnt == base; c++) idle(1);
        idle(5);
        chk("ff_done_pulses", done_cnt - base, 1);
        begin
            int ea[$];
            for (int i = 0; i < 64; i++) ea.push_back(i);
            chk_obs("ff_addr", ea);
        end
        chk("ff_busy", busy, 0);
        chk("ff_overflow", overflow, 0);

        // Backpressure: four fill the FIFO, the fifth is dropped.
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) beat(5'd5, mk((i + 1) * 64, 0, 0, 0));
        idle(1);
        chk("bp_overflow", overflow, 1);
        chk("bp_valid", m_valid, 1);
        chk("bp_addr", m_addr, 10);
        chk("bp_data", m_data, 32'h0000_0001);
        held = m_data;
        idle(3);
        chk("bp_stable", m_data, held);
        m_ready = 1'b1;
        idle(8);
        chk_obs("bp_addr_out", '{10, 11, 10, 11});
        chk("bp_sticky", overflow, 1);

        // Push at full with a simultaneous pop.
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) beat(5'd7, mk(i * 640, 0, 0, 0));
        m_ready = 1'b1;
        idle(1);
        m_ready = 1'b0;
        chk("pp_count", dut.u_fifo.count_q, 4);
        chk("pp_overflow", overflow, 0);
        m_ready = 1'b1;
        idle(8);
        chk_obs("pp_addr", '{14, 15, 14, 15, 14});
        chk("pp_overflow_end", overflow, 0);

        // Weight-map switch and beat wrap.
        do_reset();
        m_ready = 1'b1;
        beat(5'd3, mk(100, 200, 300, 400)); idle(3);
        beat(5'd4, mk(500, 600, 700, 800)); idle(3);
        beat(5'd4, mk(900, 1000, -1, 0));   idle(3);
        beat(5'd4, mk(64, 128, 192, 256));  idle(6);
        chk_obs("wm_addr", '{6, 8, 9, 8});

        // Reset mid-frame with three words queued.
        do_reset();
        m_ready = 1'b0;
        beat(5'd1, mk(640, 0, 0, 0));
        beat(5'd1, mk(1280, 0, 0, 0));
        beat(5'd2, mk(1920, 0, 0, 0));
        idle(2);
        chk("rm_queued", m_valid, 1);
        base = done_cnt;
        rst = 1'b1;
        #1;
        chk("rm_valid", m_valid, 0);
        chk("rm_busy", busy, 0);
        chk("rm_overflow", overflow, 0);
        idle(2);
        rst = 1'b0;
        idle(1);
        m_ready = 1'b1;
        obs.delete();
        beat(5'd0, mk(320, 0, 0, 0));
        idle(4);
        chk_obs("rm_next_addr", '{0});
        chk("rm_no_done", done_cnt, base);

        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", nchecks, nfail);
        $fatal(1, "watchdog");
    end

endmodule
